// File: rtl/next_packet_pkg.sv
// Shared opcodes, packet field widths, FSM/source encodings and the packet
// builder used by the output packet arbiter.
package next_packet_pkg;

  localparam int OPCODE_W   = 8;
  localparam int PAYLOAD_W  = 32;
  localparam int PACKET_W   = OPCODE_W + PAYLOAD_W;
  localparam int KB_DATA_W  = 16;
  localparam int MIC_DATA_W = 32;

  localparam logic [OPCODE_W-1:0] OP_POWER_ON = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_KB       = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_MIC      = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE     = 2'd0,
    SRC_POWER_ON = 2'd1,
    SRC_KB       = 2'd2,
    SRC_MIC      = 2'd3
  } src_t;

  // Keyboard words are zero-padded above the mouse qualifier bit.
  function automatic logic [PACKET_W-1:0] make_packet(
    input src_t                  src,
    input logic                  is_mouse,
    input logic [KB_DATA_W-1:0]  kb_word,
    input logic [MIC_DATA_W-1:0] mic_word
  );
    logic [PACKET_W-1:0] pkt;
    pkt = '0;
    case (src)
      SRC_POWER_ON: pkt = {OP_POWER_ON, {PAYLOAD_W{1'b0}}};
      SRC_KB:       pkt = {OP_KB, {(PAYLOAD_W - KB_DATA_W - 1){1'b0}}, is_mouse, kb_word};
      SRC_MIC:      pkt = {OP_MIC, mic_word};
      default:      pkt = '0;
    endcase
    return pkt;
  endfunction

endpackage

// File: rtl/packet_timeout_counter.sv
// Counts cycles spent waiting for the sender; expire is raised on the
// TIMEOUT-th waiting cycle (count TIMEOUT-1).
module packet_timeout_counter #(
  parameter int TIMEOUT = 20000
) (
  input  logic mon_clk,
  input  logic hw_reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge mon_clk) begin
    if (hw_reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = run && (count == LAST);

endmodule

// File: rtl/out_packet_arbiter.sv
// Arbitrates power-on, keyboard/mouse and microphone requests into one
// 40-bit packet stream, holding each packet until retrieved or timed out.
module out_packet_arbiter
  import next_packet_pkg::*;
#(
  parameter int TIMEOUT  = 20000,
  parameter int KB_BURST = 4
) (
  input  logic                  mon_clk,
  input  logic                  hw_reset,
  input  logic                  power_on_req,
  input  logic                  kb_valid,
  input  logic                  kb_is_mouse,
  input  logic [KB_DATA_W-1:0]  kb_data,
  output logic                  kb_ack,
  input  logic                  mic_valid,
  input  logic [MIC_DATA_W-1:0] mic_data,
  output logic                  mic_ack,
  output logic [PACKET_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_retrieved,
  output logic                  drop_pulse,
  output logic                  busy
);

  localparam int STREAK_W = ($clog2(KB_BURST + 1) > 3) ? $clog2(KB_BURST + 1) : 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(KB_BURST);

  arb_state_t          state;
  arb_state_t          next_state;
  src_t                grant;
  src_t                granted_src;
  logic [STREAK_W-1:0] kb_streak;
  logic                po_pending;
  logic                retire;
  logic                expire;
  logic                in_wait;

  assign in_wait = (state == ST_WAIT_ACK);
  assign busy    = (state != ST_IDLE);

  packet_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .mon_clk (mon_clk),
    .hw_reset(hw_reset),
    .load    (!in_wait),
    .run     (in_wait),
    .expire  (expire)
  );

  always_ff @(posedge mon_clk) begin
    if (hw_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Acks and drop are gated by reset so a packet abandoned by reset is never acked.
  always_comb begin
    next_state = state;
    grant      = SRC_NONE;
    retire     = 1'b0;
    kb_ack     = 1'b0;
    mic_ack    = 1'b0;
    drop_pulse = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (po_pending || kb_valid || mic_valid) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (po_pending) begin
          grant = SRC_POWER_ON;
        end else if (mic_valid && (kb_streak == STREAK_MAX)) begin
          grant = SRC_MIC;
        end else if (kb_valid) begin
          grant = SRC_KB;
        end else if (mic_valid) begin
          grant = SRC_MIC;
        end
        next_state = (grant == SRC_NONE) ? ST_IDLE : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        retire     = !hw_reset && (out_retrieved || expire);
        drop_pulse = !hw_reset && expire && !out_retrieved;
        kb_ack     = retire && (granted_src == SRC_KB);
        mic_ack    = retire && (granted_src == SRC_MIC);
        if (retire) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge mon_clk) begin
    if (hw_reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      granted_src <= SRC_NONE;
      kb_streak   <= '0;
      po_pending  <= 1'b0;
    end else begin
      po_pending <= (po_pending && !(retire && (granted_src == SRC_POWER_ON))) || power_on_req;
      if (grant != SRC_NONE) begin
        out_data    <= make_packet(grant, kb_is_mouse, kb_data, mic_data);
        out_valid   <= 1'b1;
        granted_src <= grant;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      // Streak only matters while mic is waiting, so a lone keyboard keeps it at zero.
      if (grant == SRC_KB) begin
        if (!mic_valid) begin
          kb_streak <= '0;
        end else if (kb_streak != STREAK_MAX) begin
          kb_streak <= kb_streak + 1'b1;
        end
      end else if (grant == SRC_MIC) begin
        kb_streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_out_packet_arbiter.sv
// Randomized self-checking bench for out_packet_arbiter with a transaction-level
// reference model of grant priority, packet formats, acks and timeout drops.
module tb_out_packet_arbiter;

  localparam int TIMEOUT  = 20000;
  localparam int KB_BURST = 4;

  localparam logic [7:0] OPC_PO  = 8'h01;
  localparam logic [7:0] OPC_KB  = 8'h02;
  localparam logic [7:0] OPC_MIC = 8'h03;

  localparam int S_NONE = 0;
  localparam int S_PO   = 1;
  localparam int S_KB   = 2;
  localparam int S_MIC  = 3;

  logic        mon_clk = 1'b0;
  logic        hw_reset = 1'b1;
  logic        power_on_req = 1'b0;
  logic        kb_valid = 1'b0;
  logic        kb_is_mouse = 1'b0;
  logic [15:0] kb_data = '0;
  logic        kb_ack;
  logic        mic_valid = 1'b0;
  logic [31:0] mic_data = '0;
  logic        mic_ack;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved = 1'b0;
  logic        drop_pulse;
  logic        busy;

  always #5 mon_clk = ~mon_clk;

  out_packet_arbiter #(
    .TIMEOUT (TIMEOUT),
    .KB_BURST(KB_BURST)
  ) dut (
    .mon_clk      (mon_clk),
    .hw_reset     (hw_reset),
    .power_on_req (power_on_req),
    .kb_valid     (kb_valid),
    .kb_is_mouse  (kb_is_mouse),
    .kb_data      (kb_data),
    .kb_ack       (kb_ack),
    .mic_valid    (mic_valid),
    .mic_data     (mic_data),
    .mic_ack      (mic_ack),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_retrieved(out_retrieved),
    .drop_pulse   (drop_pulse),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus controls: rates in percent, po_rate per thousand.
  int          kb_rate = 0, mic_rate = 0, po_rate = 0, cancel_rate = 0, spurious_rate = 0;
  int          ret_mode = 0;
  bit          kb_fixed = 0;
  logic [15:0] fixed_kb_data = '0;
  bit          fixed_mouse = 0;
  bit          force_po = 0;
  bit          rst_now = 0;

  // Reference model state.
  bit          prev_ov = 0, rst_prev = 0, retired_prev = 0;
  logic [39:0] exp_data = '0;
  int          gsrc = S_NONE, wait_cycles = 0, streak = 0, ret_delay = 0;
  bit          po_pend = 0;
  bit          p_kb_valid = 0, p_mic_valid = 0, p_po_pend = 0, p_mouse = 0;
  logic [15:0] p_kb_data = '0;
  logic [31:0] p_mic_data = '0;
  bit          kb_acked_prev = 0, mic_acked_prev = 0;
  int          last_retire = -1, rise_cycle = 0, stall_run = 0;
  bit          pend1 = 0, pend2 = 0;

  // Observations of the DUT for directed checks.
  logic [7:0]  obs_op[$];
  logic [39:0] obs_data[$];
  int          n_kb_ack = 0, n_kb_ack_ret = 0, n_drop = 0, n_retire = 0, drop_cycle = 0;
  bit          drop_mic_ack = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One clock cycle: inputs driven at the falling edge, outputs checked 1 time unit later.
  task automatic applyStimulus();
    bit          ov, ret, tmo, retire, pending;
    logic [39:0] od;
    int          src;
    @(negedge mon_clk);
    cyc++;
    ov = out_valid;
    od = out_data;

    if (rst_prev) begin
      checkOutput("rst_valid", 64'(ov), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
    end
    if (retired_prev) begin
      checkOutput("valid_drop", 64'(ov), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
    end

    if (ov && !prev_ov) begin
      if (p_po_pend) src = S_PO;
      else if (p_mic_valid && streak == KB_BURST) src = S_MIC;
      else if (p_kb_valid) src = S_KB;
      else if (p_mic_valid) src = S_MIC;
      else src = S_NONE;
      checkOutput("grant_exists", 64'(src != S_NONE), 64'd1);
      case (src)
        S_PO:    exp_data = {OPC_PO, 32'h0};
        S_KB:    exp_data = {OPC_KB, 15'h0, p_mouse, p_kb_data};
        S_MIC:   exp_data = {OPC_MIC, p_mic_data};
        default: exp_data = od;
      endcase
      if (src == S_KB) streak = p_mic_valid ? ((streak < KB_BURST) ? streak + 1 : streak) : 0;
      if (src == S_MIC) streak = 0;
      gsrc = src;
      wait_cycles = 0;
      ret_delay = $urandom_range(0, 6);
      rise_cycle = cyc;
      obs_op.push_back(od[39:32]);
      obs_data.push_back(od);
      if (last_retire >= 0) begin
        checkOutput("spacing_min", 64'((cyc - last_retire) >= 3), 64'd1);
        checkOutput("spacing_exact", 64'((cyc - last_retire) == 3), 64'(pend1 && pend2));
      end
    end
    if (ov) begin
      wait_cycles++;
      checkOutput("busy_wait", 64'(busy), 64'd1);
    end
    checkOutput("data_hold", 64'(od), 64'(exp_data));

    hw_reset = rst_now;
    if (kb_acked_prev || !kb_valid) begin
      kb_valid = ($urandom_range(0, 99) < kb_rate);
      kb_data = kb_fixed ? fixed_kb_data : 16'($urandom);
      kb_is_mouse = kb_fixed ? fixed_mouse : 1'($urandom);
    end else if (!(ov && gsrc == S_KB) && $urandom_range(0, 99) < cancel_rate) begin
      kb_valid = 1'b0;
    end
    if (mic_acked_prev || !mic_valid) begin
      mic_valid = ($urandom_range(0, 99) < mic_rate);
      mic_data = $urandom;
    end else if (!(ov && gsrc == S_MIC) && $urandom_range(0, 99) < cancel_rate) begin
      mic_valid = 1'b0;
    end
    power_on_req = force_po || ($urandom_range(0, 999) < po_rate);
    force_po = 0;
    if (ov) begin
      case (ret_mode)
        1:       ret = 1'b0;
        2:       ret = (wait_cycles == TIMEOUT);
        3:       ret = 1'b1;
        default: ret = (wait_cycles > ret_delay);
      endcase
    end else begin
      ret = ($urandom_range(0, 99) < spurious_rate);
    end
    out_retrieved = ret;

    #1;
    tmo = ov && (wait_cycles == TIMEOUT);
    retire = ov && !rst_now && (ret || tmo);
    checkOutput("kb_ack", 64'(kb_ack), 64'(retire && gsrc == S_KB));
    checkOutput("mic_ack", 64'(mic_ack), 64'(retire && gsrc == S_MIC));
    checkOutput("drop_pulse", 64'(drop_pulse), 64'(ov && !rst_now && tmo && !ret));
    if (kb_ack === 1'b1) n_kb_ack++;
    if (kb_ack === 1'b1 && ret) n_kb_ack_ret++;
    if (drop_pulse === 1'b1) begin
      n_drop++;
      drop_cycle = cyc;
      drop_mic_ack = (mic_ack === 1'b1);
    end

    pending = kb_valid || mic_valid || po_pend;
    if (cyc == last_retire + 1) pend1 = pending;
    if (cyc == last_retire + 2) pend2 = pending;
    if (rst_now || ov || !pending) stall_run = 0;
    else stall_run++;
    if (stall_run > 2) begin
      checkOutput("stall", 64'(stall_run), 64'd2);
      stall_run = 0;
    end

    p_kb_valid = kb_valid;
    p_kb_data = kb_data;
    p_mouse = kb_is_mouse;
    p_mic_valid = mic_valid;
    p_mic_data = mic_data;
    p_po_pend = po_pend;
    kb_acked_prev = retire && gsrc == S_KB;
    mic_acked_prev = retire && gsrc == S_MIC;
    retired_prev = retire;
    rst_prev = rst_now;
    if (retire) begin
      last_retire = cyc;
      n_retire++;
    end
    if (rst_now) begin
      po_pend = 0;
      streak = 0;
      gsrc = S_NONE;
      exp_data = '0;
      last_retire = -1;
      wait_cycles = 0;
      prev_ov = 0;
    end else begin
      po_pend = (po_pend && !(retire && gsrc == S_PO)) || power_on_req;
      prev_ov = ov;
    end
  endtask

  task automatic resetDut();
    kb_rate = 0; mic_rate = 0; po_rate = 0; cancel_rate = 0; spurious_rate = 0;
    ret_mode = 0; kb_fixed = 0;
    rst_now = 1;
    repeat (2) applyStimulus();
    rst_now = 0;
    obs_op.delete();
    obs_data.delete();
    n_kb_ack = 0; n_kb_ack_ret = 0; n_drop = 0; n_retire = 0; drop_mic_ack = 0;
  endtask

  initial begin
    $display("[TB] out_packet_arbiter bench start");
    resetDut();
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_kb_ack", 64'(kb_ack), 64'd0);

    // Power-on and keyboard requested together: power-on goes first.
    force_po = 1; kb_rate = 100;
    applyStimulus();
    kb_rate = 0;
    repeat (40) applyStimulus();
    checkOutput("po_kb_count", 64'(obs_op.size()), 64'd2);
    if (obs_op.size() >= 2) begin
      checkOutput("po_first", 64'(obs_data[0]), {24'h0, OPC_PO, 32'h0});
      checkOutput("kb_second", 64'(obs_op[1]), 64'(OPC_KB));
    end

    // Mouse word format and single-cycle ack coincident with retrieval.
    resetDut();
    kb_fixed = 1; fixed_kb_data = 16'h1234; fixed_mouse = 1; kb_rate = 100;
    applyStimulus();
    kb_rate = 0;
    repeat (20) applyStimulus();
    checkOutput("kb_fmt_count", 64'(obs_data.size()), 64'd1);
    if (obs_data.size() >= 1)
      checkOutput("kb_format", 64'(obs_data[0]), {24'h0, OPC_KB, 15'h0, 1'b1, 16'h1234});
    checkOutput("kb_ack_width", 64'(n_kb_ack), 64'd1);
    checkOutput("kb_ack_coincide", 64'(n_kb_ack_ret), 64'd1);

    // Both sources held: four keyboard grants then one mic grant, repeating.
    resetDut();
    kb_rate = 100; mic_rate = 100;
    for (int i = 0; i < 400 && obs_op.size() < 10; i++) applyStimulus();
    checkOutput("burst_count", 64'(obs_op.size() >= 10), 64'd1);
    for (int i = 0; i < 10 && i < obs_op.size(); i++)
      checkOutput("burst_order", 64'(obs_op[i]), 64'((i % 5 == 4) ? OPC_MIC : OPC_KB));

    // Random traffic with cancels, power-on pulses and stray retrievals.
    resetDut();
    kb_rate = 40; mic_rate = 40; po_rate = 20; cancel_rate = 5; spurious_rate = 10;
    repeat (3000) applyStimulus();
    kb_rate = 0; mic_rate = 0; po_rate = 0; cancel_rate = 0; spurious_rate = 0;
    repeat (60) applyStimulus();

    // No retrieval: packet dropped on the TIMEOUT-th edge after entry, source acked.
    resetDut();
    ret_mode = 1; mic_rate = 100;
    applyStimulus();
    mic_rate = 0;
    for (int i = 0; i < TIMEOUT + 100 && n_drop == 0; i++) applyStimulus();
    checkOutput("drop_seen", 64'(n_drop), 64'd1);
    checkOutput("drop_latency", 64'(drop_cycle - rise_cycle + 1), 64'(TIMEOUT));
    checkOutput("drop_ack", 64'(drop_mic_ack), 64'd1);
    repeat (3) applyStimulus();

    // Retrieval on the timeout cycle wins: normal ack and no drop.
    resetDut();
    ret_mode = 2; kb_rate = 100;
    applyStimulus();
    kb_rate = 0;
    for (int i = 0; i < TIMEOUT + 100 && n_retire == 0; i++) applyStimulus();
    repeat (3) applyStimulus();
    checkOutput("coincide_retired", 64'(n_retire), 64'd1);
    checkOutput("coincide_no_drop", 64'(n_drop), 64'd0);
    checkOutput("coincide_ack", 64'(n_kb_ack), 64'd1);

    // Reset while waiting, with a retrieval in the same cycle: no ack.
    resetDut();
    ret_mode = 1; kb_rate = 100;
    applyStimulus();
    kb_rate = 0;
    for (int i = 0; i < 20 && obs_op.size() == 0; i++) applyStimulus();
    checkOutput("rstwait_rise", 64'(obs_op.size()), 64'd1);
    repeat (2) applyStimulus();
    ret_mode = 3; rst_now = 1;
    applyStimulus();
    rst_now = 0; ret_mode = 0;
    applyStimulus();
    checkOutput("rstwait_data", 64'(out_data), 64'd0);
    checkOutput("rst_no_ack", 64'(n_kb_ack), 64'd0);
    repeat (30) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
